tx_stripe_serializer: RTL and testbench

TX_STRIPE_SERIALIZER -- requirements
Module: tx_stripe_serializer

---
 rtl/tx_stripe_serializer_pkg.sv | 20 ++
 rtl/tx_stripe_serializer_lane_serializer.sv | 43 ++++
 rtl/tx_stripe_serializer.sv | 116 +++++++++++
 tb/tb_tx_stripe_serializer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_stripe_serializer_pkg.sv
// -----------------------------------------------------------------------------
// tx_stripe_serializer_pkg
// Constants and the control-state encoding shared by the transmit striper and
// the matching receive deserializers, so both ends agree on lane count,
// symbol width and the idle symbol.
// -----------------------------------------------------------------------------
package tx_stripe_serializer_pkg;

  localparam int          NUM_LANES = 4;
  localparam int          SYM_BITS  = 8;
  localparam logic [7:0]  IDLE_SYM  = 8'hBC;

  // GATHER: fewer than NUM_LANES bytes collected; FULL: a complete group is
  // waiting for the next symbol boundary.
  typedef enum logic {
    ST_GATHER = 1'b0,
    ST_FULL   = 1'b1
  } state_t;

endpackage

// File: rtl/tx_stripe_serializer_lane_serializer.sv
// -----------------------------------------------------------------------------
// lane_serializer
// One lane's load/shift register. On i_load the register takes i_load_data,
// otherwise it shifts left, filling with 0. The lane bit is the register MSB,
// so symbols leave MSB first and the output is registered.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (register <- IDLE_SYM)
//   enb          enable; low holds the register
//   i_load       load i_load_data on this edge instead of shifting
//   i_load_data  symbol to load
//   o_bit        serial lane bit (register MSB)
// -----------------------------------------------------------------------------
module lane_serializer #(
  parameter int                  SYM_BITS = 8,
  parameter logic [SYM_BITS-1:0] IDLE_SYM = tx_stripe_serializer_pkg::IDLE_SYM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  input  logic                i_load,
  input  logic [SYM_BITS-1:0] i_load_data,
  output logic                o_bit
);

  logic [SYM_BITS-1:0] r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= IDLE_SYM;
    end else if (enb) begin
      if (i_load) begin
        r_shift <= i_load_data;
      end else begin
        r_shift <= {r_shift[SYM_BITS-2:0], 1'b0};
      end
    end
  end

  assign o_bit = r_shift[SYM_BITS-1];

endmodule

// File: rtl/tx_stripe_serializer.sv
// -----------------------------------------------------------------------------
// tx_stripe_serializer
// Gathers four upstream bytes and stripes them across four serial lanes, one
// byte per lane, MSB first. A free-running bit counter divides time into
// 8-cycle symbols; at each symbol boundary every lane loads either the
// gathered group (if complete) or IDLE_SYM.
//
// Handshake: a byte transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready is combinational (enb and gather not full) and does
// not depend on in_valid; upstream holds in_data/in_valid until transferred.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   enb         global enable; low freezes all state and drops in_ready
//   in_data     upstream byte
//   in_valid    in_data valid
//   in_ready    byte accepted this cycle when in_valid is also high
//   L0..L3      serial lane bits (lane k carries gather slot k)
//   lane_valid  high while the symbol on the lanes is data, low for IDLE_SYM
// -----------------------------------------------------------------------------
module tx_stripe_serializer #(
  parameter logic [7:0] IDLE_SYM = tx_stripe_serializer_pkg::IDLE_SYM,
  parameter int         SYM_BITS = tx_stripe_serializer_pkg::SYM_BITS  // only 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  input  logic [SYM_BITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                L0,
  output logic                L1,
  output logic                L2,
  output logic                L3,
  output logic                lane_valid
);

  import tx_stripe_serializer_pkg::*;

  localparam int               CNT_W    = $clog2(SYM_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_BITS - 1);

  logic [CNT_W-1:0]    r_bit_cnt;
  logic [2:0]          r_count;                // bytes gathered, 0..4
  logic [SYM_BITS-1:0] r_slot [NUM_LANES];
  state_t              r_state;
  logic                r_lane_valid;

  logic                w_boundary;
  logic                w_accept;
  logic                w_load_group;
  logic [NUM_LANES-1:0] w_lane_bit;
  logic [SYM_BITS-1:0] w_load_data [NUM_LANES];

  assign in_ready     = enb && (r_count < 3'(NUM_LANES));
  assign w_accept     = in_valid && in_ready;
  assign w_boundary   = (r_bit_cnt == LAST_BIT);
  // Decided from the state before the edge, so a 4th byte arriving on the
  // boundary edge itself waits a whole symbol for the next boundary.
  assign w_load_group = (r_state == ST_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt    <= '0;
      r_count      <= '0;
      r_state      <= ST_GATHER;
      r_lane_valid <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_slot[k] <= '0;
      end
    end else if (enb) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_boundary && w_load_group) begin
        // Group moves into the lanes; gather restarts empty.
        r_count      <= '0;
        r_state      <= ST_GATHER;
        r_lane_valid <= 1'b1;
      end else begin
        if (w_boundary) begin
          r_lane_valid <= 1'b0;    // idle symbol; partial gather is kept
        end
        if (w_accept) begin
          r_slot[r_count[1:0]] <= in_data;
          r_count              <= r_count + 3'd1;
          if (r_count == 3'(NUM_LANES - 1)) begin
            r_state <= ST_FULL;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign w_load_data[k] = w_load_group ? r_slot[k] : IDLE_SYM;

    lane_serializer #(
      .SYM_BITS (SYM_BITS),
      .IDLE_SYM (IDLE_SYM)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .enb         (enb),
      .i_load      (w_boundary),
      .i_load_data (w_load_data[k]),
      .o_bit       (w_lane_bit[k])
    );
  end

  assign L0         = w_lane_bit[0];
  assign L1         = w_lane_bit[1];
  assign L2         = w_lane_bit[2];
  assign L3         = w_lane_bit[3];
  assign lane_valid = r_lane_valid;

endmodule

// File: tb/tb_tx_stripe_serializer.sv
module tb_tx_stripe_serializer;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enb = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       L0, L1, L2, L3;
  logic       lane_valid;

  always #5 clk = ~clk;

  tx_stripe_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .L0         (L0),
    .L1         (L1),
    .L2         (L2),
    .L3         (L3),
    .lane_valid (lane_valid)
  );

  int tests = 0;
  int fails = 0;

  localparam logic [33:0] IDLE_E = {2'b00, 32'hBCBCBCBC};

  // Symbol phase model: counts enabled rising edges since reset, mod 8.
  logic [2:0] tb_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cnt <= 3'd0;
    else if (enb) tb_cnt <= tb_cnt + 3'd1;
  end

  // Monitor: rebuilds each lane symbol from the serial bits (MSB first) and
  // pushes {all_valid, any_valid, lane0, lane1, lane2, lane3} per symbol.
  logic [7:0]  mon_b0 = '0, mon_b1 = '0, mon_b2 = '0, mon_b3 = '0;
  logic        mon_vall = 1'b1, mon_vany = 1'b0;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int          valid_cycles = 0;

  always @(negedge clk) begin : mon
    automatic logic [7:0] w0, w1, w2, w3;
    automatic logic       va, vy;
    if (!reset) begin
      mon_b0 <= '0; mon_b1 <= '0; mon_b2 <= '0; mon_b3 <= '0;
      mon_vall <= 1'b1; mon_vany <= 1'b0;
    end else begin
      if (lane_valid === 1'b1) valid_cycles <= valid_cycles + 1;
      if (enb) begin
        w0 = mon_b0; w1 = mon_b1; w2 = mon_b2; w3 = mon_b3;
        w0[3'd7 - tb_cnt] = L0;
        w1[3'd7 - tb_cnt] = L1;
        w2[3'd7 - tb_cnt] = L2;
        w3[3'd7 - tb_cnt] = L3;
        va = mon_vall & lane_valid;
        vy = mon_vany | lane_valid;
        if (tb_cnt == 3'd7) begin
          obs_q.push_back({va, vy, w0, w1, w2, w3});
          mon_b0 <= '0; mon_b1 <= '0; mon_b2 <= '0; mon_b3 <= '0;
          mon_vall <= 1'b1; mon_vany <= 1'b0;
        end else begin
          mon_b0 <= w0; mon_b1 <= w1; mon_b2 <= w2; mon_b3 <= w3;
          mon_vall <= va; mon_vany <= vy;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just out of reset, one delay after a rising edge, phase 0.
  task automatic do_reset();
    reset = 1'b0; enb = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Presents n bytes first, first+inc, ... with in_valid held high.
  task automatic send_bytes(input int n, input logic [7:0] first,
                            input logic [7:0] inc, input int budget,
                            output int cyc);
    int   sent;
    logic acc;
    sent = 0; cyc = 0;
    in_valid = 1'b1; in_data = first;
    while (sent < n && cyc < budget) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        in_data = first + inc * 8'(sent);
      end
    end
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enb = 1'b0; in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({L3, L2, L1, L0, lane_valid, in_ready} !== 6'b1111_0_0) begin
      fails++;
      $display("FAIL reset_async got %b want 111100", {L3, L2, L1, L0, lane_valid, in_ready});
    end
    enb = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_follows_enb got %b want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({L3, L2, L1, L0, lane_valid} !== 5'b1111_0) begin
      fails++; $display("FAIL reset_hold got %b want 11110", {L3, L2, L1, L0, lane_valid});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({L3, L2, L1, L0, lane_valid, in_ready} !== 6'b1111_0_1) begin
      fails++;
      $display("FAIL reset_release got %b want 111101", {L3, L2, L1, L0, lane_valid, in_ready});
    end
    step();
    tests++;  // first shift exposes bit 6 of 8'hBC
    if ({L3, L2, L1, L0} !== 4'b0000) begin
      fails++; $display("FAIL reset_first_shift got %b want 0000", {L3, L2, L1, L0});
    end
  endtask

  task automatic test_idle();
    int base; bit ok; logic [33:0] got;
    do_reset();
    base = obs_q.size();
    repeat (3) exp_q.push_back(IDLE_E);
    run_until(base + 3, 40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL idle_timeout got %0d want %0d", obs_q.size() - base, 3); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL idle_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_single_group();
    int base, cyc; bit ok; logic [33:0] got;
    do_reset();
    base = obs_q.size();
    send_bytes(4, 8'h11, 8'h11, 20, cyc);
    tests++;
    if (cyc != 4) begin fails++; $display("FAIL single_accept_cycles got %0d want 4", cyc); end
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL single_ready_full got %b want 0", in_ready); end
    exp_q.push_back(IDLE_E);
    exp_q.push_back({2'b11, 32'h11223344});
    exp_q.push_back(IDLE_E);
    run_until(base + 3, 40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout got %0d want %0d", obs_q.size() - base, 3); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL single_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int base, cyc; bit ok; logic [33:0] got;
    do_reset();
    base = obs_q.size();
    send_bytes(16, 8'h00, 8'h01, 80, cyc);
    tests++;  // 4 accepted, 4 stalled while FULL, repeated; last group ends at 3*8+4
    if (cyc != 28) begin fails++; $display("FAIL b2b_accept_cycles got %0d want 28", cyc); end
    exp_q.push_back(IDLE_E);
    exp_q.push_back({2'b11, 32'h00010203});
    exp_q.push_back({2'b11, 32'h04050607});
    exp_q.push_back({2'b11, 32'h08090A0B});
    exp_q.push_back({2'b11, 32'h0C0D0E0F});
    exp_q.push_back(IDLE_E);
    run_until(base + 6, 60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d want %0d", obs_q.size() - base, 6); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL b2b_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_fourth_on_boundary();
    int base, cyc; bit ok; logic [33:0] got;
    do_reset();
    base = obs_q.size();
    repeat (4) step();  // bytes land on edges at phases 4,5,6,7
    send_bytes(4, 8'hA0, 8'h01, 20, cyc);
    tests++;
    if (cyc != 4) begin fails++; $display("FAIL bnd_accept_cycles got %0d want 4", cyc); end
    tests++;
    if ({in_ready, lane_valid} !== 2'b00) begin
      fails++; $display("FAIL bnd_not_loaded got %b want 00", {in_ready, lane_valid});
    end
    exp_q.push_back(IDLE_E);
    exp_q.push_back(IDLE_E);
    exp_q.push_back({2'b11, 32'hA0A1A2A3});
    exp_q.push_back(IDLE_E);
    run_until(base + 4, 50, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bnd_timeout got %0d want %0d", obs_q.size() - base, 4); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL bnd_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_enb_freeze();
    int base, cyc, vstart; bit ok; logic [33:0] got;
    do_reset();
    base = obs_q.size();
    vstart = valid_cycles;
    send_bytes(4, 8'h5A, 8'h11, 20, cyc);  // 5A 6B 7C 8D
    repeat (4) step();  // boundary: data symbol starts
    repeat (3) step();  // phase 3: lanes show bit 4
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({in_ready, lane_valid, L3, L2, L1, L0} !== 6'b0_1_0101) begin
        fails++;
        $display("FAIL freeze_cyc%0d got %b want 010101", i, {in_ready, lane_valid, L3, L2, L1, L0});
      end
      @(posedge clk);
      #1;
    end
    enb = 1'b1;
    exp_q.push_back(IDLE_E);
    exp_q.push_back({2'b11, 32'h5A6B7C8D});
    exp_q.push_back(IDLE_E);
    run_until(base + 3, 50, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL freeze_timeout got %0d want %0d", obs_q.size() - base, 3); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL freeze_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
    tests++;
    if (valid_cycles - vstart != 13) begin
      fails++; $display("FAIL freeze_symbol_len got %0d want 13", valid_cycles - vstart);
    end
  endtask

  task automatic test_reset_mid();
    int base, cyc; bit ok; logic [33:0] got;
    do_reset();
    send_bytes(4, 8'hD0, 8'h01, 20, cyc);
    repeat (4) step();                       // D0..D3 now on the lanes
    send_bytes(2, 8'hE1, 8'h01, 20, cyc);    // partial gather
    repeat (2) step();                       // phase 4: lanes show bit 3 = 0
    tests++;
    if ({lane_valid, L3, L2, L1, L0} !== 5'b1_0000) begin
      fails++; $display("FAIL midrst_pre got %b want 10000", {lane_valid, L3, L2, L1, L0});
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({lane_valid, L3, L2, L1, L0, in_ready} !== 6'b0_1111_1) begin
      fails++;
      $display("FAIL midrst_async got %b want 011111", {lane_valid, L3, L2, L1, L0, in_ready});
    end
    do_reset();
    base = obs_q.size();
    send_bytes(4, 8'hF0, 8'h01, 20, cyc);
    exp_q.push_back(IDLE_E);
    exp_q.push_back({2'b11, 32'hF0F1F2F3});
    exp_q.push_back(IDLE_E);
    run_until(base + 3, 40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_timeout got %0d want %0d", obs_q.size() - base, 3); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : '0;
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL midrst_sym%0d got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle();
    test_single_group();
    test_back_to_back();
    test_fourth_on_boundary();
    test_enb_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
